csa_stream_accumulator: RTL

- Parametrised sequential successor to the 16-bit bitwise 3:2 carry-save stage.
- Accepts a stream of WIDTH-bit unsigned operands over a valid/ready handshake and keeps a redundant running total as a sum vector S and a carry vector C.
- Each accepted operand passes through a WIDTH-generalised 3:2 compressor. At the last operand, one carry-propagate resolve cycle produces the final result.
- Sits in front of the prefix-adder test datapaths as a multi-operand adder. The approximate low-bit resolve is optional.

---
 rtl/csa_stream_accumulator.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/csa_stream_accumulator.sv
// -----------------------------------------------------------------------------
// csa_stream_accumulator
//
// Multi-operand adder built around a WIDTH-generalised 3:2 carry-save stage.
// Operands arrive over a valid/ready stream and are folded into a redundant
// running total (sum vector s_r, carry vector c_r). The operand flagged with
// in_last triggers one carry-propagate resolve cycle. The resolved frame sum is
// then presented on a valid/ready result port.
//
// Optional build macro: CSA_STREAM_ACCUMULATOR_APPROX_EN
//   When defined, the low APPROX_K result bits are resolved as s|c. The upper
//   bits are s+c with no carry-in from the low part. When undefined, the resolve
//   is an exact ACC_W-bit add and APPROX_K is only range-checked.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   in_data      in   WIDTH-bit unsigned operand (zero-extended to ACC_W)
//   in_valid     in   operand valid
//   in_last      in   final operand of the frame (sampled with in_data)
//   in_ready     out  block accepts an operand (ACCUM state)
//   out_data     out  ACC_W-bit frame sum, modulo 2^ACC_W
//   out_count    out  operands in the frame, saturating at MAX_OPS
//   out_overflow out  frame had more than MAX_OPS operands
//   out_valid    out  result valid (OUTPUT state)
//   out_ready    in   downstream accepts the result
// -----------------------------------------------------------------------------
module csa_stream_accumulator #(
  parameter int WIDTH    = 16,
  parameter int MAX_OPS  = 16,
  parameter int APPROX_K = 4,
  localparam int ACC_W   = WIDTH + $clog2(MAX_OPS),
  localparam int CNT_W   = $clog2(MAX_OPS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_RESOLVE = 2'd1;
  localparam logic [1:0] ST_OUTPUT  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OPS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Elaboration-time parameter sanity checks.
  if (MAX_OPS < 2 || (MAX_OPS & (MAX_OPS - 1)) != 0) begin : g_bad_max_ops
    $error("MAX_OPS must be a power of two, at least 2");
  end
  if (APPROX_K < 1 || APPROX_K > WIDTH - 1) begin : g_bad_approx_k
    $error("APPROX_K must lie in 1..WIDTH-1");
  end

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [ACC_W-1:0] s_r;
  logic [ACC_W-1:0] c_r;
  logic [CNT_W-1:0] count_r;
  logic             ovf_r;
  logic [ACC_W-1:0] out_data_r;
  logic [CNT_W-1:0] out_count_r;
  logic             out_ovf_r;

  logic             accept_s;
  logic [ACC_W-1:0] x_s;
  logic [ACC_W-1:0] carry_s;
  logic [ACC_W-1:0] s_nxt_s;
  logic [ACC_W-1:0] c_nxt_s;
  logic [ACC_W-1:0] result_s;

  assign accept_s = in_valid && (state_r == ST_ACCUM);
  assign x_s      = {{(ACC_W - WIDTH){1'b0}}, in_data};

  // 3:2 compressor: per-bit sum and majority; the majority shifted up one place
  // becomes the new carry vector and its top bit falls off (mod 2^ACC_W).
  always_comb begin
    carry_s = (s_r & c_r) | (s_r & x_s) | (c_r & x_s);
    s_nxt_s = s_r ^ c_r ^ x_s;
    c_nxt_s = carry_s << 1'b1;
  end

`ifdef CSA_STREAM_ACCUMULATOR_APPROX_EN
  // Approximate resolve: OR the low bits, add the high bits without carry-in.
  always_comb begin
    result_s                      = {ACC_W{1'b0}};
    result_s[APPROX_K-1:0]        = s_r[APPROX_K-1:0] | c_r[APPROX_K-1:0];
    result_s[ACC_W-1:APPROX_K]    = s_r[ACC_W-1:APPROX_K] + c_r[ACC_W-1:APPROX_K];
  end
`else
  // Exact resolve: full-width carry-propagate add of the redundant pair.
  always_comb begin
    result_s = s_r + c_r;
  end
`endif

  // Next-state decode for the ACCUM -> RESOLVE -> OUTPUT frame sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ACCUM: begin
        if (accept_s && in_last) begin
          state_nxt_s = ST_RESOLVE;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_RESOLVE: begin
        state_nxt_s = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_OUTPUT;
        end
      end
      default: begin
        state_nxt_s = ST_ACCUM;
      end
    endcase
  end

  // State register with the handshake flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_ACCUM;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_ACCUM);
      out_valid_r <= (state_nxt_s == ST_OUTPUT);
    end
  end

  // Accumulator, operand counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r         <= {ACC_W{1'b0}};
      c_r         <= {ACC_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      ovf_r       <= 1'b0;
      out_data_r  <= {ACC_W{1'b0}};
      out_count_r <= {CNT_W{1'b0}};
      out_ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          if (accept_s) begin
            s_r <= s_nxt_s;
            c_r <= c_nxt_s;
            // Counter parks at MAX_OPS; any further operand marks overflow.
            if (count_r == CNT_MAX) begin
              ovf_r <= 1'b1;
            end else begin
              count_r <= count_r + CNT_ONE;
            end
          end
        end
        ST_RESOLVE: begin
          out_data_r  <= result_s;
          out_count_r <= count_r;
          out_ovf_r   <= ovf_r;
          s_r         <= {ACC_W{1'b0}};
          c_r         <= {ACC_W{1'b0}};
          count_r     <= {CNT_W{1'b0}};
          ovf_r       <= 1'b0;
        end
        default: begin
          out_data_r <= out_data_r;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_data     = out_data_r;
  assign out_count    = out_count_r;
  assign out_overflow = out_ovf_r;

endmodule
